// File: rtl/track_sequencer.sv
// Track sequencer: allocates note-memory regions per track and sequences record
// and playback addresses on player ticks. Define TRACK_LOOP_EN for looped playback.
module track_sequencer #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned NUM_TRACKS = 5,
  parameter int unsigned MEM_DEPTH  = 32768
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [NUM_TRACKS-1:0] btn,
  input  logic                  rec,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic                  playing,
  output logic                  recording,
  output logic [2:0]            cur_track,
  output logic                  full
);

  localparam int unsigned PW = ADDR_W + 1;
  localparam int unsigned TW = 3;

  typedef enum logic [1:0] {IDLE, PLAY, REC} state_t;

  state_t                state;
  logic [NUM_TRACKS-1:0] btn_q;
  logic [ADDR_W-1:0]     start [NUM_TRACKS];
  logic [PW-1:0]         len   [NUM_TRACKS];
  logic [PW-1:0]         pos;
  logic [PW-1:0]         free_ptr;
  logic                  tick_q;
  logic                  stop_req;

  logic                  edge_any_c;
  logic [TW-1:0]         edge_idx_c;
  logic [PW-1:0]         cur_start_c;
  logic [PW-1:0]         cur_len_c;
  logic [PW-1:0]         edge_len_c;
  logic [PW-1:0]         pos_inc_c;
  logic [PW-1:0]         rec_stop_c;
  logic                  at_end_c;

  // Rising-edge detect; descending scan so the lowest index wins
  always_comb begin
    edge_any_c = 1'b0;
    edge_idx_c = '0;
    for (int i = int'(NUM_TRACKS) - 1; i >= 0; i--) begin
      if (btn[i] && !btn_q[i]) begin
        edge_any_c = 1'b1;
        edge_idx_c = TW'(i);
      end
    end
  end

  always_comb begin
    cur_start_c = PW'(start[cur_track]);
    cur_len_c   = len[cur_track];
    edge_len_c  = len[edge_idx_c];
    pos_inc_c   = pos + PW'(1);
    rec_stop_c  = cur_start_c + cur_len_c;
    at_end_c    = ((cur_start_c + pos) == PW'(MEM_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      btn_q     <= '0;
      pos       <= '0;
      free_ptr  <= '0;
      tick_q    <= 1'b0;
      stop_req  <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      playing   <= 1'b0;
      recording <= 1'b0;
      cur_track <= '0;
      full      <= 1'b0;
      for (int i = 0; i < int'(NUM_TRACKS); i++) begin
        start[i] <= '0;
        len[i]   <= '0;
      end
    end else begin
      btn_q    <= btn;
      mem_addr <= ADDR_W'(cur_start_c + pos);
      case (state)
        IDLE: begin
          if (edge_any_c) begin
            if (!rec) begin
              cur_track <= edge_idx_c;
              if (edge_len_c != '0) begin
                pos     <= '0;
                state   <= PLAY;
                playing <= 1'b1;
              end
            end else if (free_ptr < PW'(MEM_DEPTH)) begin
              cur_track         <= edge_idx_c;
              start[edge_idx_c] <= ADDR_W'(free_ptr);
              len[edge_idx_c]   <= '0;
              pos               <= '0;
              stop_req          <= 1'b0;
              state             <= REC;
              recording         <= 1'b1;
            end
          end
        end
        PLAY: begin
          if (edge_any_c) begin
            if (edge_idx_c == cur_track) begin
              pos     <= '0;
              state   <= IDLE;
              playing <= 1'b0;
            end else if (edge_len_c != '0) begin
              cur_track <= edge_idx_c;
              pos       <= '0;
            end
          end else if (tick) begin
            if (pos_inc_c == cur_len_c) begin
`ifdef TRACK_LOOP_EN
              pos <= '0;
`else
              pos     <= '0;
              state   <= IDLE;
              playing <= 1'b0;
`endif
            end else begin
              pos <= pos_inc_c;
            end
          end
        end
        REC: begin
          // A write in flight finishes before any stop; button stops are held in stop_req
          if (tick_q) begin
            tick_q <= 1'b0;
            mem_we <= 1'b1;
            if (edge_any_c) stop_req <= 1'b1;
          end else if (mem_we) begin
            mem_we         <= 1'b0;
            pos            <= pos_inc_c;
            len[cur_track] <= cur_len_c + PW'(1);
            if (edge_any_c) stop_req <= 1'b1;
          end else if (stop_req || edge_any_c || !rec || at_end_c) begin
            free_ptr  <= rec_stop_c;
            full      <= (rec_stop_c == PW'(MEM_DEPTH));
            pos       <= '0;
            stop_req  <= 1'b0;
            state     <= IDLE;
            recording <= 1'b0;
          end else if (tick) begin
            tick_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          playing   <= 1'b0;
          recording <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_track_sequencer.sv
// Bench for track_sequencer: directed test-plan steps followed by random
// operations, checked against an operation-level model of the track rules.
module tb_track_sequencer;

  localparam int DEPTH = 8;
  localparam int NT    = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic [4:0]  btn = '0;
  logic        rec = 1'b0;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic        playing;
  logic        recording;
  logic [2:0]  cur_track;
  logic        full;

  track_sequencer #(.ADDR_W(15), .NUM_TRACKS(NT), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn(btn), .rec(rec),
    .mem_addr(mem_addr), .mem_we(mem_we), .playing(playing),
    .recording(recording), .cur_track(cur_track), .full(full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Write monitor: every memory write address, plus any write longer than one cycle
  logic [14:0] wq[$];
  logic we_prev = 1'b0;
  int   we_long = 0;
  always @(negedge clk) begin
    if (mem_we) begin
      wq.push_back(mem_addr);
      if (we_prev) we_long++;
    end
    we_prev = mem_we;
  end

  // Model: 0 = idle, 1 = play, 2 = record
  int m_state, m_cur, m_pos, m_free, m_rec;
  bit m_full;
  int m_start[NT];
  int m_len[NT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input int mask);
    for (int i = 0; i < NT; i++) if (mask[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_state = 0; m_cur = 0; m_pos = 0; m_free = 0; m_full = 0;
    for (int i = 0; i < NT; i++) begin m_start[i] = 0; m_len[i] = 0; end
  endtask

  task automatic m_stop();
    m_state = 0;
    m_free  = m_start[m_cur] + m_len[m_cur];
    m_full  = (m_free == DEPTH);
    m_pos   = 0;
  endtask

  task automatic m_press(input int mask);
    int i;
    i = lowest(mask);
    if (i < 0) return;
    case (m_state)
      0: begin
        if (m_rec == 0) begin
          m_cur = i;
          if (m_len[i] > 0) begin m_pos = 0; m_state = 1; end
        end else if (!m_full) begin
          m_cur = i; m_start[i] = m_free; m_len[i] = 0; m_pos = 0; m_state = 2;
        end
      end
      1: begin
        if (i == m_cur) begin m_state = 0; m_pos = 0; end
        else if (m_len[i] > 0) begin m_cur = i; m_pos = 0; end
      end
      default: m_stop();
    endcase
  endtask

  task automatic m_tick(output int nwr, output int waddr);
    nwr = 0; waddr = 0;
    if (m_state == 1) begin
      if (m_pos + 1 == m_len[m_cur]) begin
        m_pos = 0;
`ifndef TRACK_LOOP_EN
        m_state = 0;
`endif
      end else begin
        m_pos++;
      end
    end else if (m_state == 2) begin
      nwr = 1;
      waddr = (m_start[m_cur] + m_pos) % 32768;
      m_pos++;
      m_len[m_cur]++;
      if (m_start[m_cur] + m_pos == DEPTH) m_stop();
    end
  endtask

  task automatic settle(input string tag, input int nwr, input int waddr);
    check({tag, "_nwrites"}, wq.size(), nwr);
    if (nwr == 1 && wq.size() > 0) check({tag, "_waddr"}, wq[0], waddr);
    check({tag, "_playing"}, playing, m_state == 1);
    check({tag, "_recording"}, recording, m_state == 2);
    check({tag, "_cur_track"}, cur_track, m_cur);
    check({tag, "_full"}, full, m_full);
    if (m_state != 0)
      check({tag, "_mem_addr"}, mem_addr, (m_start[m_cur] + m_pos) % 32768);
  endtask

  task automatic op_reset();
    wq.delete();
    reset = 1'b1; cyc(); cyc();
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_playing", playing, 0);
    check("rst_recording", recording, 0);
    check("rst_cur_track", cur_track, 0);
    check("rst_full", full, 0);
    reset = 1'b0; cyc();
    m_reset();
    wq.delete();
  endtask

  task automatic op_press(input int mask);
    wq.delete();
    btn = 5'(mask); cyc(); cyc();
    btn = '0; cyc(); cyc();
    m_press(mask);
    settle("press", 0, 0);
  endtask

  task automatic op_tick();
    int nw, wa;
    wq.delete();
    m_tick(nw, wa);
    tick = 1'b1; cyc();
    tick = 1'b0; repeat (4) cyc();
    settle("tick", nw, wa);
  endtask

  task automatic op_rec(input int v);
    wq.delete();
    rec = v[0]; cyc(); cyc();
    m_rec = v;
    if (m_state == 2 && v == 0) m_stop();
    settle("rec", 0, 0);
  endtask

  // Button edge lands while the tick's write is still in flight
  task automatic op_tick_press(input int mask);
    int nw, wa;
    wq.delete();
    m_tick(nw, wa);
    if (m_state == 2) m_stop();
    tick = 1'b1; cyc();
    tick = 1'b0; btn = 5'(mask); cyc(); cyc();
    btn = '0; repeat (3) cyc();
    settle("tick_press", nw, wa);
  endtask

  initial begin
    int r, mask;
    m_rec = 0;
    m_reset();
    op_reset();

    // Record track 0: four writes at 0..3
    op_rec(1); op_press(1);
    repeat (4) op_tick();
    op_rec(0);
    check("plan_t0_idle", recording, 0);

    // Record track 2, stopped by its own button: writes at 4,5
    op_rec(1); op_press(4);
    check("plan_t2_start_addr", mem_addr, 4);
    op_tick(); op_tick(); op_press(4);

    // Play track 2
    op_rec(0); op_press(4);
    check("plan_play_addr0", mem_addr, 4);
    op_tick();
    check("plan_play_addr1", mem_addr, 5);
    op_tick(); op_tick();
`ifdef TRACK_LOOP_EN
    op_press(4);
`endif
    check("plan_play_done", playing, 0);

    // Switch during play, then an empty-track press
    op_press(1); op_tick(); op_tick();
    check("plan_t0_pos2", mem_addr, 2);
    op_press(4);
    check("plan_switch_addr", mem_addr, 4);
    op_press(2);
    check("plan_empty_ignored", cur_track, 2);
    op_press(4);

    // Simultaneous edges: lowest index wins; zero-tick record
    op_rec(1); op_press(5'b01010);
    check("plan_multi_track", cur_track, 1);
    check("plan_multi_rec", recording, 1);
    op_rec(0);

    // Fill the remaining memory, then a record press is ignored
    op_rec(1); op_press(8); op_tick(); op_tick();
    check("plan_full", full, 1);
    op_press(16);
    check("plan_full_ignored", recording, 0);
    op_rec(0); op_press(8); op_press(8);

    // Stop coinciding with a pending write
    op_reset();
    op_rec(1); op_press(1); op_tick_press(2);
    check("coinc_cur", cur_track, 0);
    op_rec(0); op_press(1); op_tick();

    // Reset mid-record erases every track
    op_reset();
    op_rec(1); op_press(1); op_tick(); op_tick();
    op_reset();
    op_rec(0);
    for (int i = 0; i < NT; i++) op_press(1 << i);

    // Random operations
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 40) op_tick();
      else if (r < 75) begin
        if ($urandom_range(0, 9) < 7) mask = 1 << $urandom_range(0, NT - 1);
        else mask = $urandom_range(1, 31);
        op_press(mask);
      end else if (r < 96) op_rec(m_rec ^ 1);
      else op_reset();
    end

    check("we_single_cycle", we_long, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/track_sequencer.md
Name: track_sequencer

Overview:
- Controller for the shared note memory (32K x 27-bit, one port, address plus write enable).
- Manages up to NUM_TRACKS recorded tracks: allocates memory regions, sequences record and playback addresses on each player tick, and stops or switches tracks on button presses.
- Sits between the five track buttons, the record switch and the slow player-clock strobe on one side, and the memory address/write-enable on the other. Note data goes straight from key to memory.

Parameters:
- ADDR_W, 15, memory address width.
- NUM_TRACKS, 5, number of track slots; width of btn.
- MEM_DEPTH, 32768, number of memory words; record region limit.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle note-step strobe from the player clock divider; consecutive ticks are at least 3 clk apart.
- btn  input  NUM_TRACKS  track buttons, level, already debounced.
- rec  input  1  record-mode switch (1 = record).
- mem_addr  output  ADDR_W  memory address.
- mem_we  output  1  memory write enable.
- playing  output  1  high in PLAY.
- recording  output  1  high in REC.
- cur_track  output  3  active or last-selected track index.
- full  output  1  free pointer has reached MEM_DEPTH.

Behaviour:
- Reset (clk edge with reset=1): all outputs 0, state IDLE, free_ptr=0, start[i]=0, len[i]=0 for all tracks, btn history cleared. Reset applied mid-record or mid-play aborts the operation and erases every track.
- Button events: rising edges of btn, found against a registered copy. If several edges occur in one cycle, the lowest index wins and the others are dropped.
- State register: IDLE, PLAY, REC.
- Per-track state: start[i] (ADDR_W bits), len[i] (ADDR_W+1 bits). Also pos (ADDR_W+1 bits) and free_ptr (ADDR_W+1 bits).
- mem_addr = start[cur_track] + pos, truncated to ADDR_W bits, registered.
- IDLE, rec=0, edge i:
  - If len[i]>0: cur_track=i, pos=0, go to PLAY.
  - Otherwise only cur_track=i updates; state stays IDLE.
- IDLE, rec=1, edge i, full=0: cur_track=i, start[i]=free_ptr, len[i]=0, pos=0, go to REC. If full=1, the edge is ignored.
- PLAY:
  - On tick: if pos+1==len[cur_track], go to IDLE with pos=0; otherwise pos++ (mem_addr updates the next cycle).
  - Edge on cur_track: go to IDLE.
  - Edge on track j with len[j]>0: switch, cur_track=j, pos=0.
  - Edge on an empty track: ignored.
  - A change of rec is ignored during PLAY.
- REC:
  - Tick sampled at edge k: mem_we=1 for exactly cycle k+1 at the current mem_addr.
  - At edge k+2: pos++, len[cur_track]++, mem_we=0.
  - A tick arriving while mem_we=1 is ignored.
  - Stop conditions: rec falls, edge on any button, or start+pos reaching MEM_DEPTH. On stop: go to IDLE, free_ptr=start[cur_track]+len[cur_track].
  - If a stop and a pending write coincide, the write completes first and then the stop takes effect.
  - A button edge that stops REC does not start a new operation.
- Re-recording a track allocates a new region; the old region is not reclaimed.
- A record with zero ticks leaves len=0 and free_ptr unchanged.
- full = (free_ptr == MEM_DEPTH). Only reset clears it.
- playing and recording are registered decodes of the state; they are never both high.

Optional Feature:
- Macro: TRACK_LOOP_EN.
- Defined: in PLAY, a tick with pos+1==len wraps pos to 0 and playback continues. Only a button edge or reset leaves PLAY.
- Undefined: end of track returns to IDLE as described above.

Test Plan:
- Reset, then rec=1, press btn[0], 4 ticks, rec=0 -> mem_we pulses 4 times (1 cycle each) at addr 0,1,2,3; len[0]=4; free_ptr=4; state IDLE.
- Then rec=1, btn[2], 2 ticks, press btn[2] -> writes at addr 4,5; start[2]=4; free_ptr=6.
- rec=0, press btn[2], 3 ticks -> mem_addr sequence 4,5 then IDLE after the 2nd tick; playing falls. With TRACK_LOOP_EN: 4,5,4,5...
- During PLAY of track 0 at pos 2, press btn[2] -> cur_track=2, mem_addr=4 the next cycle. Press btn[1] (empty) -> no change.
- Press btn[1] and btn[3] in the same cycle in IDLE with rec=1 -> track 1 is selected and recording.
- Fill memory with MEM_DEPTH=8 -> after the 8th write, REC stops, full=1, and a further btn edge in record mode is ignored. Assert reset mid-REC -> all outputs 0 and every len is 0.
